ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch front end directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to a variable-latency instruction memory port.
- Buffers returned instructions with their PCs in a small queue and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute by flushing the queue and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h00010000, fetch PC loaded on reset.
- DEPTH, 4, queue entries; power of 2, at least 2. Also bounds outstanding requests.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  fetch address, word aligned
- imem_rsp_valid  in  1  response valid; responses return in request order
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  execute-stage PC replace (taken branch/JAL/JALR)
- redirect_pc  in  32  new fetch target
- out_valid  out  1  instruction available to IF/ID
- out_ready  in  1  IF/ID accepts (low = decode stall)
- out_instr  out  32  instruction; 32'h00000013 (NOP) when out_valid=0
- out_pc  out  32  PC of out_instr

Behaviour:
- Reset values, held while reset=1:
  - pc=RESET_PC; queue empty; inflight=0; drop_cnt=0.
  - imem_req_valid=0, out_valid=0, out_instr=NOP, out_pc=0.
- Request issue:
  - imem_req_valid=1 iff !reset && !redirect_valid && (inflight + occupancy) < DEPTH.
  - imem_req_addr=pc.
  - On req fire (valid&&ready): pc<=pc+4 (wraps modulo 2^32); inflight++.
- Response:
  - On imem_rsp_valid: inflight--.
  - If drop_cnt>0: discard the word and drop_cnt--.
  - Else push {word, pc_of_request} into the queue. Request PCs come from an internal PC FIFO of DEPTH entries, or equivalent.
- Output:
  - Queue is registered: a response accepted in cycle N is at the output no earlier than N+1.
  - Pop on out_valid && out_ready.
  - A simultaneous push and pop when full is legal. Overflow cannot occur because of the credit rule; an assertion checks this.
- Redirect (redirect_valid=1), highest priority:
  - Queue flushed next cycle; out_valid=0 in cycle N+1.
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - drop_cnt <= inflight − (imem_rsp_valid ? 1 : 0) + pending drop_cnt bookkeeping, i.e. the count of all responses still owed after this cycle.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle; the first request at the new PC goes out in cycle N+1.
  - A pop in the redirect cycle still completes (the execute stage already flushes younger stages).
  - Back-to-back redirects: the last one wins.
- Decode stall:
  - out_ready=0 holds out_instr/out_pc stable while out_valid=1.
  - Fetch continues until credit is exhausted, then imem_req_valid=0.
- Memory stall: imem_req_ready=0 holds imem_req_addr stable while imem_req_valid=1, unless a redirect arrives.
- Reset mid-operation: all state cleared on the next edge. Responses still outstanding after reset are not tracked; the memory must also be reset.
- Width rules:
  - inflight and drop_cnt are $clog2(DEPTH)+1 bits.
  - Occupancy counter is $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro IFETCH_PERF_COUNTERS_EN.
- When defined, adds outputs perf_stall_cycles[31:0] and perf_redirects[31:0], both reset to 0 and saturating at 32'hFFFFFFFF:
  - perf_stall_cycles increments each cycle with out_valid=1 && out_ready=0.
  - perf_redirects increments each cycle with redirect_valid=1.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ifetch_pkg holds:
  - INSTR_W=32, XLEN=32, NOP_INSTR=32'h00000013.
  - typedef fetch_entry_t {logic [31:0] instr; logic [31:0] pc;}.
- Sub-module ifetch_fifo:
  - Parameterised synchronous FIFO of fetch_entry_t with flush, push, pop, full, empty and count.
  - Instantiated for the instruction queue; a second instance holds request PCs.

Test Plan:
1. Reset, then imem 1-cycle latency with out_ready=1 → requests at 0x00010000, 0x00010004, 0x00010008…; out_pc follows the same sequence with out_instr equal to the memory contents; no bubbles after fill.
2. out_ready=0 for 10 cycles with DEPTH=4 → at most 4 requests outstanding or queued; imem_req_valid drops; out_instr/out_pc stable; the order resumes intact when ready returns.
3. 3-cycle memory latency with 3 in flight, then redirect to 0x00020002 → next request addr 0x00020000; the 3 stale responses are dropped; the first out_pc after redirect is 0x00020000.
4. Redirect in the same cycle as imem_rsp_valid → that response is not delivered; drop_cnt equals remaining inflight; no stale PC ever appears at the output.
5. imem_req_ready=0 for 5 cycles → imem_req_addr held; no pc increment; reset asserted mid-stall → pc=0x00010000, out_valid=0 next cycle.
6. With IFETCH_PERF_COUNTERS_EN: 7 stall cycles and 2 redirects → perf_stall_cycles=7, perf_redirects=2.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;
    localparam int          INSTR_W   = 32;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush. Data is read straight from storage, so an
// entry pushed in cycle N is visible at dout from cycle N+1.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is accepted only when a pop frees the slot.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, response queue,
// redirect flush with stale-response dropping. Optional IFETCH_PERF_COUNTERS_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00010000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_redirects
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   occupancy;
    logic [CW-1:0]   drop_cnt;
    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            q_push;
    logic            q_pop;
    logic            q_full;
    logic            q_empty;
    logic            pc_full;
    logic            pc_empty;
    logic [XLEN-1:0] rsp_pc;
    fetch_entry_t    q_din;
    fetch_entry_t    q_dout;

    // Outstanding requests plus queued entries never exceed DEPTH, so every
    // response always has a queue slot waiting for it.
    assign credit_used    = {1'b0, inflight} + {1'b0, occupancy};
    assign imem_req_valid = !reset && !redirect_valid && !pc_full &&
                            (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign q_push    = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign q_din     = '{instr: imem_rsp_data, pc: rsp_pc};
    assign out_valid = !reset && !q_empty;
    assign q_pop     = out_valid && out_ready;
    assign out_instr = out_valid ? q_dout.instr : NOP_INSTR;
    assign out_pc    = out_valid ? q_dout.pc : '0;

    // Request PCs, popped by every response (kept or dropped); its count is inflight.
    ifetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_pc_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (req_fire),
        .din   (pc),
        .pop   (imem_rsp_valid),
        .dout  (rsp_pc),
        .full  (pc_full),
        .empty (pc_empty),
        .count (inflight)
    );

    ifetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_instr_q (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (occupancy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            // Every response still owed after this cycle belongs to the old path.
            drop_cnt <= inflight - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) pc <= pc + 32'd4;
            if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(q_push && q_full && !q_pop));
            assert (!(imem_rsp_valid && pc_empty));
        end
    end

`ifdef IFETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else begin
            if (out_valid && !out_ready && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_valid && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: in-order variable-latency memory model and
// an epoch-tagged expected-delivery queue as the reference.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h00010000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFETCH_PERF_COUNTERS_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;
`endif

    ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef IFETCH_PERF_COUNTERS_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;
    int epoch   = 0;
    int exp_stall = 0;
    int exp_redir = 0;
    logic [31:0] req_exp = RESET_PC;

    // Memory model: outstanding requests in issue order, each with due cycle and epoch.
    logic [31:0]  mq_addr [$];
    int           mq_due  [$];
    int           mq_ep   [$];
    // Reference: entries the DUT must present, in order.
    fetch_entry_t eq [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579BDF;
    endfunction

    // One clock cycle: drive memory, check DUT against the reference, advance the model.
    task automatic step(input logic mem_rdy);
        logic        rsp;
        logic        exp_rv;
        logic        fire_req;
        logic [31:0] a;
        int          ep;
        rsp = (mq_due.size() > 0) && (mq_due[0] <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mq_addr[0]) : $urandom;
        imem_req_ready = mem_rdy;
        #1;
        if (reset) begin
            n_tests++;
            if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 ||
                out_instr !== NOP_INSTR || out_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got rv=%b ov=%b instr=%h pc=%h, expected 0 0 %h 0",
                         imem_req_valid, out_valid, out_instr, out_pc, NOP_INSTR);
            end
            mq_addr.delete(); mq_due.delete(); mq_ep.delete(); eq.delete();
            req_exp = RESET_PC; epoch = 0; exp_stall = 0; exp_redir = 0;
        end else begin
            exp_rv = !redirect_valid && ((mq_addr.size() + eq.size()) < DEPTH);
            n_tests++;
            if (imem_req_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL req_valid cyc %0d: got %b expected %b", cyc, imem_req_valid, exp_rv);
            end
            if (exp_rv) begin
                n_tests++;
                if (imem_req_addr !== req_exp) begin
                    n_fail++;
                    $display("FAIL req_addr cyc %0d: got %h expected %h", cyc, imem_req_addr, req_exp);
                end
            end
            n_tests++;
            if (out_valid !== (eq.size() > 0)) begin
                n_fail++;
                $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, out_valid, eq.size() > 0);
            end
            if (eq.size() > 0) begin
                n_tests++;
                if (out_pc !== eq[0].pc || out_instr !== eq[0].instr) begin
                    n_fail++;
                    $display("FAIL out_data cyc %0d: got pc=%h instr=%h expected pc=%h instr=%h",
                             cyc, out_pc, out_instr, eq[0].pc, eq[0].instr);
                end
            end else begin
                n_tests++;
                if (out_instr !== NOP_INSTR) begin
                    n_fail++;
                    $display("FAIL out_nop cyc %0d: got %h expected %h", cyc, out_instr, NOP_INSTR);
                end
            end
            fire_req = exp_rv && mem_rdy;
            if (eq.size() > 0) begin
                if (out_ready) void'(eq.pop_front());
                else exp_stall++;
            end
            if (rsp) begin
                a  = mq_addr.pop_front();
                void'(mq_due.pop_front());
                ep = mq_ep.pop_front();
                if (!redirect_valid && ep == epoch)
                    eq.push_back('{instr: mem_word(a), pc: a});
            end
            if (fire_req) begin
                mq_addr.push_back(req_exp);
                mq_due.push_back(cyc + lat);
                mq_ep.push_back(epoch);
                req_exp = req_exp + 32'd4;
            end
            if (redirect_valid) begin
                eq.delete();
                epoch++;
                exp_redir++;
                req_exp = {redirect_pc[31:2], 2'b00};
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        reset = 1'b0;
        #1;
        n_tests++;
        if (imem_req_addr !== 32'h00010000 || imem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pc: got addr=%h valid=%b expected 00010000 1", imem_req_addr, imem_req_valid);
        end
    endtask

    task automatic test_stream();
        lat = 1; out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i >= 4) begin
                n_tests++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL no_bubble cyc %0d: got out_valid=%b expected 1", cyc, out_valid);
                end
            end
            step(1'b1);
        end
    endtask

    task automatic test_decode_stall();
        logic [31:0] held_pc;
        out_ready = 1'b0;
        #1 held_pc = out_pc;
        for (int i = 0; i < 10; i++) step(1'b1);
        n_tests++;
        if (out_pc !== held_pc || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_stall: got pc=%h req_valid=%b expected pc=%h req_valid=0",
                     out_pc, imem_req_valid, held_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1);
    endtask

    task automatic test_redirect();
        int n;
        lat = 3; out_ready = 1'b1;
        n = 0;
        while (mq_addr.size() != 3 && n < 20) begin step(1'b1); n++; end
        n_tests++;
        if (mq_addr.size() != 3) begin
            n_fail++;
            $display("FAIL redirect_setup: got %0d in flight expected 3", mq_addr.size());
        end
        redirect_valid = 1'b1; redirect_pc = 32'h00020002;
        step(1'b1);
        redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (imem_req_addr !== 32'h00020000) begin
            n_fail++;
            $display("FAIL redirect_addr: got %h expected 00020000", imem_req_addr);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin step(1'b1); #1; n++; end
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h00020000) begin
            n_fail++;
            $display("FAIL redirect_first_pc: got valid=%b pc=%h expected 1 00020000", out_valid, out_pc);
        end
        for (int i = 0; i < 10; i++) step(1'b1);
    endtask

    task automatic test_redirect_rsp();
        int n;
        lat = 2; out_ready = 1'b1;
        n = 0;
        while (!(mq_due.size() > 1 && mq_due[0] <= cyc) && n < 20) begin step(1'b1); n++; end
        n_tests++;
        if (!(mq_due.size() > 0 && mq_due[0] <= cyc)) begin
            n_fail++;
            $display("FAIL redirect_rsp_setup: got no response due at cycle %0d expected one", cyc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h00030000 + {$urandom_range(0, 255), 2'b00};
        step(1'b1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1);
    endtask

    task automatic test_mem_stall();
        logic [31:0] held;
        lat = 1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1);
        #1 held = imem_req_addr;
        for (int i = 0; i < 5; i++) step(1'b0);
        #1;
        n_tests++;
        if (imem_req_addr !== held) begin
            n_fail++;
            $display("FAIL mem_stall_hold: got %h expected %h", imem_req_addr, held);
        end
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || imem_req_addr !== 32'h00010000) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got valid=%b addr=%h expected 0 00010000", out_valid, imem_req_addr);
        end
        for (int i = 0; i < 10; i++) step(1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            reset          = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 3) != 0);
        end
        reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1);
`ifdef IFETCH_PERF_COUNTERS_EN
        n_tests++;
        if (perf_stall_cycles !== 32'(exp_stall) || perf_redirects !== 32'(exp_redir)) begin
            n_fail++;
            $display("FAIL perf_random: got stall=%0d redir=%0d expected %0d %0d",
                     perf_stall_cycles, perf_redirects, exp_stall, exp_redir);
        end
`endif
    endtask

`ifdef IFETCH_PERF_COUNTERS_EN
    task automatic test_perf();
        reset = 1'b1; step(1'b1); reset = 1'b0;
        lat = 1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) step(1'b1);
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            redirect_valid = 1'b1; redirect_pc = 32'h00040000;
            step(1'b1);
            redirect_valid = 1'b0;
            for (int i = 0; i < 3; i++) step(1'b1);
        end
        n_tests++;
        if (perf_stall_cycles !== 32'd7 || perf_redirects !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_counts: got stall=%0d redir=%0d expected 7 2", perf_stall_cycles, perf_redirects);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_decode_stall();
        test_redirect();
        test_redirect_rsp();
        test_mem_stall();
        test_random();
`ifdef IFETCH_PERF_COUNTERS_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
